avg_frame_reader: RTL

AVG_FRAME_READER -- requirements
Module: avg_frame_reader

---
 rtl/avg_frame_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/avg_frame_reader.sv
// Purpose : buffers one M-word frame of accumulated sums, then streams it out scaled by >> SHIFT.
// Latency : first out word valid 2 cycles after the edge that captures word M-1, then 1 word/cycle.
// Backpr. : out_ready low holds the current word; input words arriving while draining are dropped (overflow).
//
// Ports:
//   clk, reset_n            single rising-edge clock, asynchronous active-low reset
//   in_data, in_valid       accumulated sample stream, one word per cycle, no backpressure
//   out_data, out_valid,    scaled frame stream with valid/ready handshake
//   out_ready
//   out_first, out_last     current out word is index 0 / index M-1
//   frame_count             frames fully drained, wraps at 16 bits
//   overflow, ovf_clr       sticky dropped-word flag and its clear pulse (a new drop beats the clear)
//   busy                    high while draining
//
// Build option: define AVG_READER_ROUND_EN to round half up when scaling; default truncates.
module avg_frame_reader #(
  parameter int M     = 32,
  parameter int SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic [15:0] frame_count,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        busy
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

`ifdef AVG_READER_ROUND_EN
  // Half of the divisor; the guarded shift amount keeps SHIFT=0 from producing a negative shift.
  localparam logic [32:0] RND = (SHIFT > 0) ? (33'd1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 33'd0;
`else
  localparam logic [32:0] RND = 33'd0;
`endif

  logic [31:0]   mem [M];

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    start_q, start_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] rd_nxt;

  // 33-bit sum so that adding the rounding constant to 0xFFFFFFFF cannot wrap.
  function automatic logic [31:0] scale(input logic [31:0] w);
    logic [32:0] s;
    s = {1'b0, w} + RND;
    s = s >> SHIFT;
    return s[31:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    start_d     = start_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    rd_nxt      = rd_idx_q + IW'(1);

    // Set takes priority over clear when both happen on the same edge.
    if (state_q == DRAIN && in_valid) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (state_q == FILL) begin
      if (in_valid) begin
        if (wr_idx_q == LAST_IDX) begin
          wr_idx_d = '0;
          state_d  = DRAIN;
          start_d  = 2'b01;
        end else begin
          wr_idx_d = wr_idx_q + IW'(1);
        end
      end
    end else begin
      // start_q is a two-stage delay that presents word 0 on the second edge after entering DRAIN.
      start_d = {start_q[0], 1'b0};
      if (start_q[1]) begin
        rd_idx_d    = '0;
        out_data_d  = scale(mem[0]);
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_d    = '0;
          out_valid_d = 1'b0;
          state_d     = FILL;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          rd_idx_d   = rd_nxt;
          out_data_d = scale(mem[rd_nxt]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      start_q     <= 2'b00;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      start_q     <= start_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Frame storage is not reset; a partial frame is simply overwritten after reset.
  always_ff @(posedge clk) begin
    if (state_q == FILL && in_valid) begin
      mem[wr_idx_q] <= in_data;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_first   = out_valid_q && (rd_idx_q == '0);
  assign out_last    = out_valid_q && (rd_idx_q == LAST_IDX);
  assign frame_count = frame_cnt_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == DRAIN);

endmodule
